// File: rtl/dmem_byteen_ram_pkg.sv
// Shared definitions for the byte-enabled data memory: controller states,
// read-latency limits and a constant-foldable ceil(log2) helper.
package dmem_byteen_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RD_LAT_MAX = 2;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= 0) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_byteen_ram_if.sv
// Bus between the MEM stage (master) and the data memory (slave): request,
// read response, init status and the store-trace stream.
interface dmem_byteen_ram_if #(
    parameter int DATA_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [BYTES-1:0]  req_byteen;
    logic [DATA_W-1:0] req_wdata;
    logic [31:0]       req_pc;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_busy;
    logic              trc_valid;
    logic              trc_ready;
    logic [31:0]       trc_pc;
    logic [31:0]       trc_addr;
    logic [DATA_W-1:0] trc_data;
    logic              trc_overflow;

    modport master (
        output req_valid, req_addr, req_byteen, req_wdata, req_pc, trc_ready,
        input  req_ready, rsp_valid, rsp_rdata, init_busy,
               trc_valid, trc_pc, trc_addr, trc_data, trc_overflow
    );

    modport slave (
        input  req_valid, req_addr, req_byteen, req_wdata, req_pc, trc_ready,
        output req_ready, rsp_valid, rsp_rdata, init_busy,
               trc_valid, trc_pc, trc_addr, trc_data, trc_overflow
    );

endinterface

// File: rtl/dmem_trace_fifo.sv
// Store-trace FIFO: valid/ready pop, a push into a full FIFO survives only
// when a pop frees a slot in the same cycle, otherwise it is dropped and a
// sticky overflow flag is raised. Outputs hold the last popped record when empty.
module dmem_trace_fifo
    import dmem_byteen_ram_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push_valid,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overflow
);
    localparam int IDX_W = clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_last;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_head;

    // Extra pointer MSB tells full (MSBs differ) from empty (all equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_pop   = !w_empty && i_pop_ready;
    assign w_push  = i_push_valid && (!w_full || w_pop);
    assign w_drop  = i_push_valid && !w_push;
    assign w_head  = r_mem[r_rd_ptr[IDX_W-1:0]];

    // Record storage; a full push with pop reuses the slot being read out.
    // NOTE: storage carries no reset -- the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
        end
    end

    // Pointers, held output record and sticky overflow.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_last   <= w_head;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? r_last : w_head;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/dmem_byteen_ram.sv
// Byte-enabled data memory for the MIPS MEM stage: zero-fill sweep after
// reset, byte-lane merging stores, 0..2 cycle read latency and a store trace.
module dmem_byteen_ram
    import dmem_byteen_ram_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int TRC_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    dmem_byteen_ram_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam int TRC_W = 64 + DATA_W;

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("dmem_byteen_ram: RD_LAT must be 0, 1 or 2");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    logic [IDX_W-1:0]  r_sweep_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]  w_idx;
    logic              w_fire;
    logic              w_fire_wr;
    logic              w_fire_rd;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_merged;
    logic [31:0]       w_aligned;
    logic [TRC_W-1:0]  w_trc_rec;
    logic              w_unused_addr;

    // Offset bits and bits above ADDR_W are ignored, so addresses alias.
    assign w_idx         = bus.req_addr[ADDR_W-1:OFF_W];
    assign w_unused_addr = ^bus.req_addr;
    assign w_aligned     = bus.req_addr & ~(32'(BYTES) - 32'd1);

    assign bus.req_ready = (r_state == ST_RUN);
    assign bus.init_busy = (r_state == ST_INIT);

    assign w_fire    = bus.req_valid && bus.req_ready;
    assign w_fire_wr = w_fire && (|bus.req_byteen);
    assign w_fire_rd = w_fire && !(|bus.req_byteen);
    assign w_rd_word = r_mem[w_idx];

    // State register and sweep pointer; the sweep restarts from word 0 on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_sweep_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_sweep_ptr <= r_sweep_ptr + IDX_W'(1);
            end
        end
    end

    // Next state: leave INIT once the last word has been cleared.
    // NOTE: default assigned first so no path through the block infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_sweep_ptr == '1) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Old word with the enabled byte lanes replaced by the store data.
    always_comb begin
        w_merged = w_rd_word;
        for (int b = 0; b < BYTES; b++) begin
            if (bus.req_byteen[b]) begin
                w_merged[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
        end
    end

    // Array writes; the sweep also clears word 0 while reset is held, which
    // is harmless since the same word is cleared again after release.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_sweep_ptr] <= '0;
        end else if (w_fire_wr) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    if (RD_LAT == 0) begin : g_rd_comb
        logic [DATA_W-1:0] r_hold;

        // Remember the last returned word so rsp_rdata holds between reads.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_hold <= '0;
            end else if (w_fire_rd) begin
                r_hold <= w_rd_word;
            end
        end

        assign bus.rsp_valid = w_fire_rd;
        assign bus.rsp_rdata = w_fire_rd ? w_rd_word : r_hold;
    end else begin : g_rd_pipe
        logic [RD_LAT-1:0] r_vld;
        logic [DATA_W-1:0] r_dat [RD_LAT];

        // Data is captured at accept, so later writes cannot alter a read in flight.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_vld <= '0;
                for (int k = 0; k < RD_LAT; k++) begin
                    r_dat[k] <= '0;
                end
            end else begin
                r_vld[0] <= w_fire_rd;
                if (w_fire_rd) begin
                    r_dat[0] <= w_rd_word;
                end
                for (int k = 1; k < RD_LAT; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_dat[k] <= r_dat[k-1];
                    end
                end
            end
        end

        assign bus.rsp_valid = r_vld[RD_LAT-1];
        assign bus.rsp_rdata = r_dat[RD_LAT-1];
    end

    dmem_trace_fifo #(
        .WIDTH (TRC_W),
        .DEPTH (TRC_DEPTH)
    ) u_trace_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (w_fire_wr),
        .i_push_data  ({bus.req_pc, w_aligned, w_merged}),
        .i_pop_ready  (bus.trc_ready),
        .o_valid      (bus.trc_valid),
        .o_data       (w_trc_rec),
        .o_overflow   (bus.trc_overflow)
    );

    assign bus.trc_pc   = w_trc_rec[TRC_W-1 -: 32];
    assign bus.trc_addr = w_trc_rec[DATA_W +: 32];
    assign bus.trc_data = w_trc_rec[DATA_W-1:0];

endmodule

// File: tb/tb_dmem_byteen_ram.sv
// Bench for dmem_byteen_ram: three instances (read latency 0, 1, 2) share one
// stimulus stream and are compared every cycle against a word-array model.
module tb_dmem_byteen_ram;

    localparam int NLAT  = 3;
    localparam int DEPTH = 16;   // ADDR_W = 6, 4-byte words
    localparam int TDEP  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_byteen = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        trc_ready = 1'b0;

    logic        o_ready [NLAT];
    logic        o_busy  [NLAT];
    logic        o_rv    [NLAT];
    logic [31:0] o_rd    [NLAT];
    logic        o_tv    [NLAT];
    logic [31:0] o_tpc   [NLAT];
    logic [31:0] o_taddr [NLAT];
    logic [31:0] o_tdata [NLAT];
    logic        o_ovf   [NLAT];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar L = 0; L < NLAT; L++) begin : g_dut
        dmem_byteen_ram_if #(.DATA_W(32)) bus ();

        assign bus.req_valid  = req_valid;
        assign bus.req_addr   = req_addr;
        assign bus.req_byteen = req_byteen;
        assign bus.req_wdata  = req_wdata;
        assign bus.req_pc     = req_pc;
        assign bus.trc_ready  = trc_ready;

        assign o_ready[L] = bus.req_ready;
        assign o_busy[L]  = bus.init_busy;
        assign o_rv[L]    = bus.rsp_valid;
        assign o_rd[L]    = bus.rsp_rdata;
        assign o_tv[L]    = bus.trc_valid;
        assign o_tpc[L]   = bus.trc_pc;
        assign o_taddr[L] = bus.trc_addr;
        assign o_tdata[L] = bus.trc_data;
        assign o_ovf[L]   = bus.trc_overflow;

        dmem_byteen_ram #(
            .ADDR_W    (6),
            .DATA_W    (32),
            .RD_LAT    (L),
            .TRC_DEPTH (TDEP)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    rec_t        m_trq [$];
    rec_t        m_last;
    bit          m_ovf;
    int          m_init_left;
    bit          m_hv [2];        // read accepted at the most recent edge [0] and the one before [1]
    logic [31:0] m_hd [2];
    logic [31:0] m_hold [NLAT];   // last data each latency variant returned
    bit          m_fire_wr, m_fire_rd;
    int          m_w;
    logic [31:0] m_word;

    function automatic int word_of(input logic [31:0] a);
        return int'((a % 32'd64) / 32'd4);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_trq.delete();
            m_last      = '0;
            m_ovf       = 1'b0;
            m_init_left = DEPTH;
            m_hv[0] = 1'b0; m_hv[1] = 1'b0;
            m_hd[0] = '0;   m_hd[1] = '0;
            for (int i = 0; i < NLAT; i++) m_hold[i] = '0;
        end else begin
            m_fire_wr = (m_init_left == 0) && req_valid && (req_byteen != 4'd0);
            m_fire_rd = (m_init_left == 0) && req_valid && (req_byteen == 4'd0);
            m_w       = word_of(req_addr);
            m_word    = m_mem[m_w];
            if (m_trq.size() > 0 && trc_ready) m_last = m_trq.pop_front();
            if (m_fire_rd) m_hold[0] = m_word;
            m_hv[1] = m_hv[0];    m_hd[1] = m_hd[0];
            m_hv[0] = m_fire_rd;  m_hd[0] = m_word;
            if (m_hv[0]) m_hold[1] = m_hd[0];
            if (m_hv[1]) m_hold[2] = m_hd[1];
            if (m_fire_wr) begin
                for (int b = 0; b < 4; b++)
                    if (req_byteen[b]) m_word[8*b +: 8] = req_wdata[8*b +: 8];
                m_mem[m_w] = m_word;
                if (m_trq.size() < TDEP)
                    m_trq.push_back('{pc: req_pc, addr: req_addr & 32'hFFFF_FFFC, data: m_word});
                else
                    m_ovf = 1'b1;
            end
            if (m_init_left > 0) m_init_left--;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          e_rdy, e_fire_rd, e_rv;
    logic [31:0] e_rd;
    rec_t        e_rec;

    always @(negedge clk) begin
        if (chk_en) begin
            e_rdy     = reset && (m_init_left == 0);
            e_fire_rd = e_rdy && req_valid && (req_byteen == 4'd0);
            e_rec     = (m_trq.size() > 0) ? m_trq[0] : m_last;
            for (int L = 0; L < NLAT; L++) begin
                if (L == 0) begin
                    e_rv = e_fire_rd;
                    e_rd = e_fire_rd ? m_mem[word_of(req_addr)] : m_hold[0];
                end else begin
                    e_rv = m_hv[L-1];
                    e_rd = m_hold[L];
                end
                check($sformatf("lat%0d req_ready", L), o_ready[L], e_rdy);
                check($sformatf("lat%0d init_busy", L), o_busy[L], !e_rdy);
                check($sformatf("lat%0d rsp_valid", L), o_rv[L], e_rv);
                check($sformatf("lat%0d rsp_rdata", L), o_rd[L], e_rd);
                check($sformatf("lat%0d trc_valid", L), o_tv[L], m_trq.size() > 0);
                check($sformatf("lat%0d trc_pc", L), o_tpc[L], e_rec.pc);
                check($sformatf("lat%0d trc_addr", L), o_taddr[L], e_rec.addr);
                check($sformatf("lat%0d trc_data", L), o_tdata[L], e_rec.data);
                check($sformatf("lat%0d trc_overflow", L), o_ovf[L], m_ovf);
            end
        end
    end

    // ---------------- directed helpers (inputs change 1 after posedge) ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string nm);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            @(negedge clk);
            if (!o_busy[0]) break;
            cnt++;
        end
        check({nm, " busy cycles"}, cnt, DEPTH);
        check({nm, " ready after init"}, o_ready[2], 1);
        cyc();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, input logic [31:0] pc);
        req_valid = 1'b1; req_addr = a; req_byteen = be; req_wdata = d; req_pc = pc;
        cyc();
        req_valid = 1'b0; req_byteen = '0;
    endtask

    task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
        int          first [NLAT];
        logic [31:0] dat   [NLAT];
        for (int L = 0; L < NLAT; L++) begin first[L] = -1; dat[L] = '0; end
        req_valid = 1'b1; req_addr = a; req_byteen = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int L = 0; L < NLAT; L++)
                if (o_rv[L] && first[L] < 0) begin first[L] = k; dat[L] = o_rd[L]; end
            cyc();
            req_valid = 1'b0;
        end
        for (int L = 0; L < NLAT; L++) begin
            check($sformatf("%s lat%0d latency", nm, L), first[L], L);
            check($sformatf("%s lat%0d data", nm, L), dat[L], exp);
        end
    endtask

    task automatic pop_check(input string nm, input logic [31:0] epc,
                             input logic [31:0] ea, input logic [31:0] ed);
        trc_ready = 1'b1;
        @(negedge clk);
        check({nm, " trc_valid"}, o_tv[1], 1);
        check({nm, " trc_pc"}, o_tpc[1], epc);
        check({nm, " trc_addr"}, o_taddr[1], ea);
        check({nm, " trc_data"}, o_tdata[1], ed);
        cyc();
        trc_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        cyc();
        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset ready", o_ready[0], 0);
        check("reset busy", o_busy[0], 1);
        check("reset rsp_rdata lat2", o_rd[2], 32'h0);
        cyc();
        reset = 1'b1;
        wait_init("first init");

        do_read("zero word7", 32'h1C, 32'h0000_0000);

        // Byte-lane merge, then read-after-write on the next cycle.
        do_write(32'h10, 4'b1111, 32'h1122_3344, 32'h400);
        do_write(32'h10, 4'b0101, 32'hAABB_CCDD, 32'h404);
        do_read("merge raw", 32'h10, 32'h11BB_33DD);
        pop_check("merge rec1", 32'h400, 32'h10, 32'h1122_3344);
        pop_check("merge rec2", 32'h404, 32'h10, 32'h11BB_33DD);

        // Aliasing: 0x43 lands on word 0 with aligned address 0x40.
        do_write(32'h43, 4'b1111, 32'hDEAD_BEEF, 32'h408);
        pop_check("alias rec", 32'h408, 32'h40, 32'hDEAD_BEEF);
        do_read("alias read", 32'h00, 32'hDEAD_BEEF);

        // Fill the trace FIFO, then overflow it.
        for (int i = 0; i < 5; i++) begin
            do_write(32'h20 + 32'(4 * i), 4'b1111, 32'hA000_0000 + 32'(i), 32'h500 + 32'(4 * i));
            @(negedge clk);
            check($sformatf("overflow after store %0d", i + 1), o_ovf[0], (i == 4) ? 1 : 0);
            cyc();
        end
        do_read("dropped store in mem", 32'h30, 32'hA000_0004);

        // Push into full FIFO while popping: must not be dropped.
        trc_ready = 1'b1;
        do_write(32'h34, 4'b1111, 32'hB000_0006, 32'h600);
        trc_ready = 1'b0;
        for (int i = 1; i < 4; i++)
            pop_check($sformatf("full rec%0d", i + 1), 32'h500 + 32'(4 * i), 32'h20 + 32'(4 * i),
                      32'hA000_0000 + 32'(i));
        pop_check("push-pop rec", 32'h600, 32'h34, 32'hB000_0006);
        @(negedge clk);
        check("fifo drained", o_tv[0], 0);
        check("overflow sticky", o_ovf[0], 1);
        cyc();

        // Async reset between accept and response of a read.
        do_write(32'h08, 4'b0011, 32'h0000_1234, 32'h700);
        req_valid = 1'b1; req_addr = 32'h08; req_byteen = '0;
        cyc();
        req_valid = 1'b0;
        #1 reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int L = 0; L < NLAT; L++) seen |= o_rv[L];
        end
        check("no rsp after reset", seen, 0);
        check("fifo empty after reset", o_tv[0], 0);
        check("overflow cleared", o_ovf[0], 0);
        cyc();
        reset = 1'b1;
        wait_init("reinit");
        do_read("reinit zero", 32'h08, 32'h0);

        // Randomised traffic, including requests during init and a reset pulse.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) reset = 1'b0;
            if (c == 703) reset = 1'b1;
            req_valid  = ($urandom_range(0, 3) != 0);
            req_addr   = $urandom_range(0, 255);
            req_byteen = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
            req_wdata  = $urandom;
            req_pc     = $urandom;
            trc_ready  = ($urandom_range(0, 2) == 0);
            cyc();
        end
        req_valid = 1'b0;
        trc_ready = 1'b1;
        repeat (8) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
